// File: rtl/rf_access_arbiter_pkg.sv
// Shared definitions for the register-file access arbiter.
package rf_access_arbiter_pkg;

    localparam int unsigned RF_DATA_WIDTH = 32;
    localparam int unsigned RF_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rf_access_arbiter_rr_pick.sv
// Combinational 2-way round-robin picker: on a tie the requester not granted last wins.
module rf_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic winner,
    output logic valid
);

    // Tie goes to the requester that did not own the file last time.
    always_comb begin
        valid  = req0 | req1;
        winner = (req0 & req1) ? ~last_gnt : req1;
    end

endmodule

// File: rtl/rf_access_arbiter.sv
// Two-requester register-file access arbiter, one access in flight at a time.
module rf_access_arbiter
    import rf_access_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = RF_DATA_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      REQ0,
    input  logic                      REQ1,
    input  logic                      WE0,
    input  logic                      WE1,
    input  logic [REG_ADDR_WIDTH-1:0] ADDRA0,
    input  logic [REG_ADDR_WIDTH-1:0] ADDRA1,
    input  logic [REG_ADDR_WIDTH-1:0] ADDRB0,
    input  logic [REG_ADDR_WIDTH-1:0] ADDRB1,
    input  logic [DATA_WIDTH-1:0]     WDATA0,
    input  logic [DATA_WIDTH-1:0]     WDATA1,
    output logic                      GNT0,
    output logic                      GNT1,
    output logic                      DONE0,
    output logic                      DONE1,
    output logic [DATA_WIDTH-1:0]     RDATA1,
    output logic [DATA_WIDTH-1:0]     RDATA2,
    output logic                      RF_READ,
    output logic                      RF_WRITE,
    output logic [REG_ADDR_WIDTH-1:0] RF_ADDR_R1,
    output logic [REG_ADDR_WIDTH-1:0] RF_ADDR_R2,
    output logic [REG_ADDR_WIDTH-1:0] RF_ADDR_W,
    output logic [DATA_WIDTH-1:0]     RF_DATA_W,
    input  logic [DATA_WIDTH-1:0]     RF_DATA_R1,
    input  logic [DATA_WIDTH-1:0]     RF_DATA_R2
);

    arb_state_e                state_q, state_d;
    logic [1:0]                gnt_q, gnt_d;
    logic                      own_q, own_d;
    logic                      last_q, last_d;
    logic                      we_q, we_d;
    logic [REG_ADDR_WIDTH-1:0] addr_r1_q, addr_r1_d;
    logic [REG_ADDR_WIDTH-1:0] addr_r2_q, addr_r2_d;
    logic [REG_ADDR_WIDTH-1:0] addr_w_q, addr_w_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]     rdata1_q, rdata1_d;
    logic [DATA_WIDTH-1:0]     rdata2_q, rdata2_d;

    logic                      pick_win;
    logic                      pick_valid;
    logic                      sel_we;
    logic [REG_ADDR_WIDTH-1:0] sel_addra;
    logic [REG_ADDR_WIDTH-1:0] sel_addrb;
    logic [DATA_WIDTH-1:0]     sel_wdata;

    rf_rr_pick u_pick (
        .req0     (REQ0),
        .req1     (REQ1),
        .last_gnt (last_q),
        .winner   (pick_win),
        .valid    (pick_valid)
    );

    // Operand mux for whichever requester the picker chose this cycle.
    always_comb begin
        sel_we    = pick_win ? WE1    : WE0;
        sel_addra = pick_win ? ADDRA1 : ADDRA0;
        sel_addrb = pick_win ? ADDRB1 : ADDRB0;
        sel_wdata = pick_win ? WDATA1 : WDATA0;
    end

    // Next-state and latch logic; one FSM state per cycle.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        own_d     = own_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_r1_d = addr_r1_q;
        addr_r2_d = addr_r2_q;
        addr_w_d  = addr_w_q;
        wdata_d   = wdata_q;
        rdata1_d  = rdata1_q;
        rdata2_d  = rdata2_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_ISSUE;
                    own_d   = pick_win;
                    gnt_d   = pick_win ? 2'b10 : 2'b01;
                    we_d    = sel_we;
                    if (sel_we) begin
                        addr_w_d = sel_addra;
                        wdata_d  = sel_wdata;
                    end else begin
                        addr_r1_d = sel_addra;
                        addr_r2_d = sel_addrb;
                    end
                end
            end
            ST_ISSUE: state_d = we_q ? ST_DONE : ST_WAIT;
            ST_WAIT: begin
                rdata1_d = RF_DATA_R1;
                rdata2_d = RF_DATA_R2;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                gnt_d   = '0;
                last_d  = own_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            own_q     <= 1'b0;
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            addr_r1_q <= '0;
            addr_r2_q <= '0;
            addr_w_q  <= '0;
            wdata_q   <= '0;
            rdata1_q  <= '0;
            rdata2_q  <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            own_q     <= own_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_r1_q <= addr_r1_d;
            addr_r2_q <= addr_r2_d;
            addr_w_q  <= addr_w_d;
            wdata_q   <= wdata_d;
            rdata1_q  <= rdata1_d;
            rdata2_q  <= rdata2_d;
        end
    end

    // Strobes only in ISSUE; DONE pulses for the current owner in the DONE state.
    always_comb begin
        GNT0       = gnt_q[0];
        GNT1       = gnt_q[1];
        DONE0      = (state_q == ST_DONE) && gnt_q[0];
        DONE1      = (state_q == ST_DONE) && gnt_q[1];
        RF_WRITE   = (state_q == ST_ISSUE) && we_q;
        RF_READ    = (state_q == ST_ISSUE) && !we_q;
        RF_ADDR_R1 = addr_r1_q;
        RF_ADDR_R2 = addr_r2_q;
        RF_ADDR_W  = addr_w_q;
        RF_DATA_W  = wdata_q;
        RDATA1     = rdata1_q;
        RDATA2     = rdata2_q;
    end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Self-checking bench for rf_access_arbiter with a behavioural register-file model.
module tb_rf_access_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ0, REQ1, WE0, WE1;
    logic [4:0]  ADDRA0, ADDRA1, ADDRB0, ADDRB1;
    logic [31:0] WDATA0, WDATA1;
    logic        GNT0, GNT1, DONE0, DONE1;
    logic [31:0] RDATA1, RDATA2;
    logic        RF_READ, RF_WRITE;
    logic [4:0]  RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W;
    logic [31:0] RF_DATA_W;
    wire  [31:0] RF_DATA_R1, RF_DATA_R2;

    int n_vec = 0;
    int n_err = 0;
    bit started = 1'b0;

    logic [31:0] rf_mem  [32];
    logic [31:0] exp_mem [32];
    logic        rd_v;
    logic [31:0] rd1, rd2;

    logic        t_we [2];
    logic [4:0]  t_a  [2];
    logic [4:0]  t_b  [2];
    logic [31:0] t_d  [2];
    int          last_w;

    always #5 CLK = ~CLK;

    rf_access_arbiter #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDRA0(ADDRA0), .ADDRA1(ADDRA1), .ADDRB0(ADDRB0), .ADDRB1(ADDRB1),
        .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
        .RDATA1(RDATA1), .RDATA2(RDATA2),
        .RF_READ(RF_READ), .RF_WRITE(RF_WRITE),
        .RF_ADDR_R1(RF_ADDR_R1), .RF_ADDR_R2(RF_ADDR_R2), .RF_ADDR_W(RF_ADDR_W),
        .RF_DATA_W(RF_DATA_W), .RF_DATA_R1(RF_DATA_R1), .RF_DATA_R2(RF_DATA_R2)
    );

    // Register file: reg0 reads as zero, read data valid the cycle after RF_READ.
    always @(posedge CLK) begin
        if (RF_WRITE && RF_ADDR_W != 5'd0) rf_mem[RF_ADDR_W] <= RF_DATA_W;
        rd_v <= RF_READ;
        rd1  <= rf_mem[RF_ADDR_R1];
        rd2  <= rf_mem[RF_ADDR_R2];
    end
    assign RF_DATA_R1 = rd_v ? rd1 : 'z;
    assign RF_DATA_R2 = rd_v ? rd2 : 'z;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Safety properties checked every cycle once out of the initial reset.
    always @(negedge CLK) begin
        if (started) begin
            chk("rd_and_wr", {63'd0, RF_READ & RF_WRITE}, 64'd0);
            chk("gnt_overlap", {63'd0, GNT0 & GNT1}, 64'd0);
            chk("done0_wo_gnt", {63'd0, DONE0 & ~GNT0}, 64'd0);
            chk("done1_wo_gnt", {63'd0, DONE1 & ~GNT1}, 64'd0);
        end
    end

    // One arbitrated access, started at a negedge while the DUT is idle and
    // ending at the negedge of the following idle cycle.
    task automatic txn(input logic [1:0] mask, input bit hold);
        int          w, lat;
        logic        we_w;
        logic [4:0]  a, b;
        logic [31:0] d;
        REQ0 = mask[0]; WE0 = t_we[0]; ADDRA0 = t_a[0]; ADDRB0 = t_b[0]; WDATA0 = t_d[0];
        REQ1 = mask[1]; WE1 = t_we[1]; ADDRA1 = t_a[1]; ADDRB1 = t_b[1]; WDATA1 = t_d[1];
        w    = (mask == 2'b11) ? 1 - last_w : (mask[1] ? 1 : 0);
        we_w = t_we[w];
        a    = t_a[w];
        b    = t_b[w];
        d    = t_d[w];
        lat  = we_w ? 3 : 4;
        for (int c = 1; c < lat; c++) begin
            @(negedge CLK);
            chk("gnt0", GNT0, w == 0);
            chk("gnt1", GNT1, w == 1);
            chk("done", {DONE1, DONE0}, (c == lat - 1) ? (w == 1 ? 2'b10 : 2'b01) : 2'b00);
            chk("rf_write", RF_WRITE, (c == 1) && we_w);
            chk("rf_read", RF_READ, (c == 1) && !we_w);
            if (we_w) begin
                chk("rf_addr_w", RF_ADDR_W, a);
                chk("rf_data_w", RF_DATA_W, d);
            end else begin
                chk("rf_addr_r1", RF_ADDR_R1, a);
                chk("rf_addr_r2", RF_ADDR_R2, b);
            end
            if (c == 1) begin
                if (w == 0) begin
                    WE0 = 1'($urandom); ADDRA0 = 5'($urandom); ADDRB0 = 5'($urandom); WDATA0 = $urandom;
                end else begin
                    WE1 = 1'($urandom); ADDRA1 = 5'($urandom); ADDRB1 = 5'($urandom); WDATA1 = $urandom;
                end
            end
            if (c == lat - 1) begin
                if (!we_w) begin
                    chk("rdata1", RDATA1, exp_mem[a]);
                    chk("rdata2", RDATA2, exp_mem[b]);
                end
                if (!hold) begin
                    REQ0 = 1'b0;
                    REQ1 = 1'b0;
                end
            end
        end
        if (we_w && a != 5'd0) exp_mem[a] = d;
        last_w = w;
        @(negedge CLK);
        chk("idle_gnt", {GNT1, GNT0}, 2'b00);
        chk("idle_done", {DONE1, DONE0}, 2'b00);
        chk("idle_strobe", {RF_READ, RF_WRITE}, 2'b00);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf_mem[i]  = '0;
            exp_mem[i] = '0;
        end
        rd_v = 1'b0; rd1 = '0; rd2 = '0;
        RST = 1'b1;
        REQ0 = 1'b0; REQ1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0;
        ADDRA0 = '0; ADDRA1 = '0; ADDRB0 = '0; ADDRB1 = '0;
        WDATA0 = '0; WDATA1 = '0;
        for (int r = 0; r < 2; r++) begin
            t_we[r] = 1'b0; t_a[r] = '0; t_b[r] = '0; t_d[r] = '0;
        end
        last_w = 1;

        repeat (2) @(negedge CLK);
        chk("rst_gnt", {GNT1, GNT0}, 2'b00);
        chk("rst_done", {DONE1, DONE0}, 2'b00);
        chk("rst_strobe", {RF_READ, RF_WRITE}, 2'b00);
        chk("rst_rdata", {RDATA1, RDATA2}, 64'd0);
        chk("rst_addr", {RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W}, 15'd0);
        chk("rst_wdata", RF_DATA_W, 32'd0);
        RST = 1'b0;
        started = 1'b1;

        // Requester 0 writes 0xA5 to r5.
        t_we[0] = 1'b1; t_a[0] = 5'd5; t_d[0] = 32'h0000_00A5;
        txn(2'b01, 1'b0);
        // Requester 1 reads r5 / r0.
        t_we[1] = 1'b0; t_a[1] = 5'd5; t_b[1] = 5'd0;
        txn(2'b10, 1'b0);

        // Both hold write requests: grants must alternate starting with requester 0.
        t_we[0] = 1'b1; t_a[0] = 5'd7; t_d[0] = 32'h1111_2222;
        t_we[1] = 1'b1; t_a[1] = 5'd9; t_d[1] = 32'h3333_4444;
        for (int k = 0; k < 4; k++) txn(2'b11, 1'b1);
        REQ0 = 1'b0; REQ1 = 1'b0;
        @(negedge CLK);

        // All-ones through register 31.
        t_we[1] = 1'b1; t_a[1] = 5'd31; t_d[1] = 32'hFFFF_FFFF;
        txn(2'b10, 1'b0);
        t_we[0] = 1'b0; t_a[0] = 5'd31; t_b[0] = 5'd31;
        txn(2'b01, 1'b0);

        // Reset during WAIT of a read: aborted without DONE, read data cleared.
        REQ1 = 1'b1; WE1 = 1'b0; ADDRA1 = 5'd31; ADDRB1 = 5'd31;
        @(negedge CLK);
        chk("abort_issue_rd", RF_READ, 1'b1);
        @(negedge CLK);
        RST = 1'b1;
        REQ1 = 1'b0;
        @(negedge CLK);
        chk("abort_gnt", {GNT1, GNT0}, 2'b00);
        chk("abort_done", {DONE1, DONE0}, 2'b00);
        chk("abort_rdata", {RDATA1, RDATA2}, 64'd0);
        chk("abort_rf_read", RF_READ, 1'b0);
        RST = 1'b0;
        @(negedge CLK);
        chk("abort_no_done", {DONE1, DONE0}, 2'b00);
        last_w = 1;

        // Tie after reset goes to requester 0 again.
        t_we[0] = 1'b1; t_a[0] = 5'd3; t_d[0] = 32'hCAFE_0003;
        t_we[1] = 1'b1; t_a[1] = 5'd4; t_d[1] = 32'hCAFE_0004;
        txn(2'b11, 1'b0);

        // Randomized mix of reads and writes from one or both requesters.
        for (int i = 0; i < 60; i++) begin
            for (int r = 0; r < 2; r++) begin
                t_we[r] = 1'($urandom);
                t_a[r]  = 5'($urandom);
                t_b[r]  = 5'($urandom);
                t_d[r]  = $urandom;
            end
            txn(2'($urandom_range(3, 1)), 1'($urandom));
            REQ0 = 1'b0; REQ1 = 1'b0;
            if (GNT0 | GNT1) begin
                chk("stray_grant", {GNT1, GNT0}, 2'b00);
            end
            @(negedge CLK);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rf_access_arbiter.md
RF_ACCESS_ARBITER -- requirements
Module: rf_access_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register data width.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, register index width (32 registers).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 REQ0, REQ1  input  1  requester n access request, level-held until DONEn.
REQ-006 WE0, WE1  input  1  requester n operation: 1 = write, 0 = read; held with REQn.
REQ-007 ADDRA0, ADDRA1  input  REG_ADDR_WIDTH  read port 1 address (read) or write address (write).
REQ-008 ADDRB0, ADDRB1  input  REG_ADDR_WIDTH  read port 2 address (ignored on write).
REQ-009 WDATA0, WDATA1  input  DATA_WIDTH  write data (ignored on read).
REQ-010 GNT0, GNT1  output  1  requester n owns the register file; one-hot or zero.
REQ-011 DONE0, DONE1  output  1  one-cycle completion pulse for requester n.
REQ-012 RDATA1, RDATA2  output  DATA_WIDTH  registered read results, shared by both requesters.
REQ-013 RF_READ, RF_WRITE  output  1  register file strobes, never both 1.
REQ-014 RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W  output  REG_ADDR_WIDTH  register file addresses.
REQ-015 RF_DATA_W  output  DATA_WIDTH  register file write data.
REQ-016 RF_DATA_R1, RF_DATA_R2  input  DATA_WIDTH  register file read data, valid the cycle after RF_READ; Z otherwise.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, DONE; at most one access in flight.
REQ-018 IDLE: if any REQn, latch winner, its WE, addresses and data; assert GNTn; go to ISSUE next cycle.
REQ-019 Arbitration round-robin: when both request, grant the requester not granted last; LAST_GNT resets to 1, so requester 0 wins the first tie.
REQ-020 ISSUE (one cycle): drive latched addresses/data; RF_WRITE=1 if write, else RF_READ=1; next WAIT if read, DONE if write.
REQ-021 WAIT (one cycle): RF_READ=0; capture RF_DATA_R1/R2 into RDATA1/RDATA2 at the end of the cycle; next DONE.
REQ-022 DONE (one cycle): DONEn=1 for the granted requester; GNTn deasserts at end of cycle; LAST_GNT updated; next IDLE.
REQ-023 Latency from REQn sampled in IDLE to DONEn: write 3 cycles, read 4 cycles; RDATA valid in the DONE cycle and held until the next read capture.
REQ-024 Back-to-back: at least one IDLE cycle between accesses; a requester holding REQ after DONE re-arbitrates in that IDLE.
REQ-025 Requests changing while granted are ignored (operands latched in IDLE); deasserting REQn mid-access does not abort it.
REQ-026 Outside ISSUE: RF_READ=RF_WRITE=0; RF address/data outputs hold latched values.
REQ-027 Write to address 0 is passed through unchanged; register-0 semantics are owned by the register file.

Reset
REQ-028 RST=1 at a rising edge: state IDLE, GNT*=0, DONE*=0, RF_READ=RF_WRITE=0, RDATA1=RDATA2=0, RF addresses/data=0, LAST_GNT=1.
REQ-029 Reset mid-access aborts it with no DONE and no further strobe; a write already strobed in ISSUE is not undone.

Structure
REQ-030 DATA_WIDTH, REG_ADDR_WIDTH defaults and FSM state encodings live in the shared project definitions header.
REQ-031 One sub-module, rf_rr_pick: combinational 2-way round-robin picker (REQ0, REQ1, LAST_GNT -> winner, valid).

Verification
REQ-032 RST pulse then REQ0 write, ADDRA0=5, WDATA0=32'h0000_00A5 -> GNT0 next cycle, RF_WRITE one cycle with RF_ADDR_W=5, DONE0 3 cycles after REQ sampled.
REQ-033 After 032, REQ1 read, ADDRA1=5, ADDRB1=0 (RF reg0 = 0) -> RF_READ one cycle, DONE1 4 cycles after REQ, RDATA1=32'hA5, RDATA2=0.
REQ-034 REQ0 and REQ1 asserted together and held, both writes -> grants alternate 0,1,0,1; no overlap; exactly one DONE per grant.
REQ-035 Write 32'hFFFF_FFFF to register 31 via requester 1, then read 31/31 via requester 0 -> RDATA1=RDATA2=32'hFFFF_FFFF.
REQ-036 RST asserted in WAIT of a read -> next cycle IDLE, no DONE, RDATA1=RDATA2=0, RF_READ=0.
REQ-037 Every cycle check: RF_READ & RF_WRITE = 0, GNT0 & GNT1 = 0, DONEn only while GNTn.
